// File: rtl/fila_ctrl.sv
// Access controller for the 8-entry fila queue: round-robin enqueue arbitration
// between two producers and a two-cycle dequeue sequence for one consumer.
module fila_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_10KHz,
  input  logic             reset,
  input  logic             prod_a_req,
  input  logic [WIDTH-1:0] prod_a_data,
  output logic             prod_a_ack,
  input  logic             prod_b_req,
  input  logic [WIDTH-1:0] prod_b_data,
  output logic             prod_b_ack,
  input  logic             cons_req,
  output logic [WIDTH-1:0] cons_data,
  output logic             cons_valid,
  output logic [WIDTH-1:0] q_data,
  output logic             q_enqueue,
  output logic             q_dequeue,
  input  logic [WIDTH-1:0] q_data_out,
  output logic [3:0]       count,
  output logic             full,
  output logic             empty
);

  localparam logic [3:0] DepthCnt = 4'(DEPTH);

  typedef enum logic [2:0] {StIdle, StEnq, StArm, StCommit, StCapture, StDone} state_e;

  state_e           state_q, state_d;
  logic             rr_q, rr_d;      // 1: producer B favoured on a tie
  logic             turn_q, turn_d;  // 1: enqueue favoured on a tie
  logic [3:0]       count_q, count_d;
  logic [WIDTH-1:0] q_data_q, q_data_d;
  logic [WIDTH-1:0] cons_data_q, cons_data_d;
  logic             q_enq_q, q_enq_d;
  logic             q_deq_q, q_deq_d;
  logic             ack_a_q, ack_a_d;
  logic             ack_b_q, ack_b_d;
  logic             valid_q, valid_d;

  logic deq_ok, enq_ok, take_deq, grant_b;

  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == 4'd0);

  assign deq_ok   = cons_req && !empty;
  assign enq_ok   = (prod_a_req || prod_b_req) && !full;
  assign take_deq = deq_ok && (!enq_ok || !turn_q);
  assign grant_b  = prod_b_req && (!prod_a_req || rr_q);

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    turn_d      = turn_q;
    count_d     = count_q;
    q_data_d    = q_data_q;
    cons_data_d = cons_data_q;
    q_enq_d     = 1'b0;
    q_deq_d     = 1'b0;
    ack_a_d     = 1'b0;
    ack_b_d     = 1'b0;
    valid_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (take_deq) begin
          q_deq_d = 1'b1;
          count_d = count_q - 4'd1;
          turn_d  = ~turn_q;
          state_d = StArm;
        end else if (enq_ok) begin
          q_enq_d  = 1'b1;
          q_data_d = grant_b ? prod_b_data : prod_a_data;
          ack_a_d  = ~grant_b;
          ack_b_d  = grant_b;
          rr_d     = ~grant_b;
          count_d  = count_q + 4'd1;
          turn_d   = ~turn_q;
          state_d  = StEnq;
        end
      end
      StEnq:     state_d = StIdle;
      StArm:     state_d = StCommit;
      StCommit:  state_d = StCapture;
      StCapture: begin
        cons_data_d = q_data_out;
        valid_d     = 1'b1;
        state_d     = StDone;
      end
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      rr_q        <= 1'b0;
      turn_q      <= 1'b0;
      count_q     <= 4'd0;
      q_data_q    <= '0;
      cons_data_q <= '0;
      q_enq_q     <= 1'b0;
      q_deq_q     <= 1'b0;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      turn_q      <= turn_d;
      count_q     <= count_d;
      q_data_q    <= q_data_d;
      cons_data_q <= cons_data_d;
      q_enq_q     <= q_enq_d;
      q_deq_q     <= q_deq_d;
      ack_a_q     <= ack_a_d;
      ack_b_q     <= ack_b_d;
      valid_q     <= valid_d;
    end
  end

  assign count      = count_q;
  assign q_data     = q_data_q;
  assign q_enqueue  = q_enq_q;
  assign q_dequeue  = q_deq_q;
  assign prod_a_ack = ack_a_q;
  assign prod_b_ack = ack_b_q;
  assign cons_valid = valid_q;
  assign cons_data  = cons_data_q;

endmodule

// File: tb/tb_fila_ctrl.sv
// Directed bench for fila_ctrl with a behavioural fila queue model
// (enqueue write at the next edge, dequeue arm then shift one edge later).
module tb_fila_ctrl;

  logic       clk_10KHz = 1'b0;
  logic       reset = 1'b1;
  logic       prod_a_req = 1'b0, prod_b_req = 1'b0, cons_req = 1'b0;
  logic [7:0] prod_a_data = '0, prod_b_data = '0;
  logic       prod_a_ack, prod_b_ack, cons_valid, q_enqueue, q_dequeue, full, empty;
  logic [7:0] cons_data, q_data;
  logic [7:0] q_data_out;
  logic [3:0] count;

  int n_pass = 0;
  int n_total = 0;

  fila_ctrl #(.WIDTH(8), .DEPTH(8)) dut (
    .clk_10KHz  (clk_10KHz),
    .reset      (reset),
    .prod_a_req (prod_a_req),
    .prod_a_data(prod_a_data),
    .prod_a_ack (prod_a_ack),
    .prod_b_req (prod_b_req),
    .prod_b_data(prod_b_data),
    .prod_b_ack (prod_b_ack),
    .cons_req   (cons_req),
    .cons_data  (cons_data),
    .cons_valid (cons_valid),
    .q_data     (q_data),
    .q_enqueue  (q_enqueue),
    .q_dequeue  (q_dequeue),
    .q_data_out (q_data_out),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always #50 clk_10KHz = ~clk_10KHz;

  // Behavioural fila queue
  logic [7:0] mem [8];
  int         len;
  logic       armed;

  always @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      len        <= 0;
      armed      <= 1'b0;
      q_data_out <= '0;
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else begin
      armed <= q_dequeue;
      if (armed && len > 0) begin
        q_data_out <= mem[0];
        for (int i = 0; i < 7; i++) mem[i] <= mem[i+1];
        len <= len - 1;
      end else if (q_enqueue && len < 8) begin
        mem[len] <= q_data;
        len      <= len + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_10KHz);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    prod_a_req = 1'b0;
    prod_b_req = 1'b0;
    cons_req = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic enq_a(input logic [7:0] d);
    prod_a_req  = 1'b1;
    prod_a_data = d;
    tick();
    chk("enq_a_ack", 32'(prod_a_ack), 1);
    prod_a_req = 1'b0;
    tick();
  endtask

  // Enqueue and dequeue must never drive the queue together
  always @(negedge clk_10KHz)
    if (!reset) chk("no_overlap", 32'(q_enqueue & q_dequeue), 0);

  initial begin
    logic [7:0] exp_data;
    logic [7:0] exp_cons [3];
    int         n_ops, n_valid;

    // Reset state
    tick();
    chk("rst_q_enqueue", 32'(q_enqueue), 0);
    chk("rst_q_dequeue", 32'(q_dequeue), 0);
    chk("rst_q_data", 32'(q_data), 0);
    chk("rst_acks", 32'({prod_a_ack, prod_b_ack}), 0);
    chk("rst_cons", 32'({cons_valid, cons_data}), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty_full", 32'({empty, full}), 'b10);
    reset = 1'b0;

    // Single enqueue from A
    prod_a_req  = 1'b1;
    prod_a_data = 8'h11;
    tick();
    chk("t1_q_enqueue", 32'(q_enqueue), 1);
    chk("t1_ack_a", 32'(prod_a_ack), 1);
    chk("t1_ack_b", 32'(prod_b_ack), 0);
    chk("t1_q_data", 32'(q_data), 'h11);
    chk("t1_count", 32'(count), 1);
    chk("t1_empty", 32'(empty), 0);
    prod_a_req = 1'b0;
    tick();
    chk("t1_enq_drop", 32'({q_enqueue, prod_a_ack}), 0);

    // Round-robin fill to full
    do_reset();
    prod_a_req = 1'b1;
    prod_a_data = 8'hA0;
    prod_b_req = 1'b1;
    prod_b_data = 8'hB0;
    for (int g = 0; g < 8; g++) begin
      tick();
      exp_data = (g % 2 == 0) ? 8'(8'hA0 + g / 2) : 8'(8'hB0 + g / 2);
      chk("rr_ack_a", 32'(prod_a_ack), (g % 2 == 0) ? 1 : 0);
      chk("rr_ack_b", 32'(prod_b_ack), (g % 2 == 1) ? 1 : 0);
      chk("rr_q_data", 32'(q_data), 32'(exp_data));
      chk("rr_count", 32'(count), g + 1);
      if (prod_a_ack) prod_a_data = prod_a_data + 8'd1;
      if (prod_b_ack) prod_b_data = prod_b_data + 8'd1;
      tick();
      chk("rr_gap", 32'(q_enqueue), 0);
    end
    chk("rr_full", 32'(full), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("full_no_ack", 32'({prod_a_ack, prod_b_ack, q_enqueue}), 0);
    end
    chk("full_count", 32'(count), 8);

    // Dequeue timing after three enqueues
    do_reset();
    enq_a(8'h01);
    enq_a(8'h02);
    enq_a(8'h03);
    cons_req = 1'b1;
    tick();
    chk("dq_e0_q_dequeue", 32'(q_dequeue), 1);
    chk("dq_e0_count", 32'(count), 2);
    tick();
    chk("dq_e1_q_dequeue", 32'(q_dequeue), 0);
    chk("dq_e1_valid", 32'(cons_valid), 0);
    tick();
    chk("dq_e2_valid", 32'(cons_valid), 0);
    tick();
    chk("dq_e3_valid", 32'(cons_valid), 1);
    chk("dq_e3_data", 32'(cons_data), 'h01);
    cons_req = 1'b0;
    tick();
    chk("dq_e4_valid", 32'(cons_valid), 0);
    chk("dq_e4_held", 32'(cons_data), 'h01);
    tick();
    chk("dq_e5_idle", 32'(q_dequeue), 0);
    chk("dq_count", 32'(count), 2);

    // Consumer waits while empty
    do_reset();
    cons_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wait_no_deq", 32'({q_dequeue, cons_valid}), 0);
    end
    prod_a_req  = 1'b1;
    prod_a_data = 8'h55;
    tick();
    chk("wait_ack_a", 32'(prod_a_ack), 1);
    prod_a_req = 1'b0;
    tick();
    tick();
    chk("wait_q_dequeue", 32'(q_dequeue), 1);
    chk("wait_count", 32'(count), 0);
    tick();
    tick();
    tick();
    chk("wait_valid", 32'(cons_valid), 1);
    chk("wait_data", 32'(cons_data), 'h55);
    cons_req = 1'b0;

    // Alternating service with both sides held
    do_reset();
    enq_a(8'h10);
    enq_a(8'h11);
    enq_a(8'h12);
    enq_a(8'h13);
    exp_cons[0] = 8'h10;
    exp_cons[1] = 8'h11;
    exp_cons[2] = 8'h12;
    n_ops = 0;
    n_valid = 0;
    cons_req = 1'b1;
    prod_a_req = 1'b1;
    prod_a_data = 8'h20;
    for (int c = 0; c < 21; c++) begin
      tick();
      chk("alt_enq_only_in_enq", 32'(q_enqueue), 32'(prod_a_ack));
      if (q_enqueue || q_dequeue) begin
        chk("alt_order", 32'(q_enqueue), n_ops % 2);
        n_ops++;
      end
      if (q_enqueue) prod_a_data = prod_a_data + 8'd1;
      if (cons_valid) begin
        if (n_valid < 3) chk("alt_cons_data", 32'(cons_data), 32'(exp_cons[n_valid]));
        n_valid++;
      end
    end
    cons_req = 1'b0;
    prod_a_req = 1'b0;
    chk("alt_n_ops", n_ops, 6);
    chk("alt_n_valid", n_valid, 3);
    chk("alt_count", 32'(count), 4);

    // Reset during COMMIT
    do_reset();
    enq_a(8'h77);
    enq_a(8'h78);
    cons_req = 1'b1;
    tick();
    chk("mid_q_dequeue", 32'(q_dequeue), 1);
    tick();
    reset = 1'b1;
    #2;
    chk("mid_rst_outputs",
        32'({q_enqueue, q_dequeue, prod_a_ack, prod_b_ack, cons_valid}), 0);
    chk("mid_rst_data", 32'({q_data, cons_data}), 0);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid_no_valid", 32'({cons_valid, q_dequeue}), 0);
    end
    cons_req = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fila_ctrl.md
# fila_ctrl

Access controller and scheduler for the 8-entry `fila` queue. It arbitrates two producers round-robin onto the queue's single enqueue port and serves one consumer through the queue's two-cycle dequeue. It guarantees that enqueue and dequeue never overlap at the queue, and it keeps its own occupancy count because the queue's `len_out` lags by one cycle. It sits between the producer/consumer logic and one `fila` instance, and shares that instance's clock and reset.

## Interface
- `WIDTH`, 8: data width; must match `fila`.
- `DEPTH`, 8: queue capacity; must match `fila`.
- `clk_10KHz`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; shared with `fila`.
- `prod_a_req`  in  1  producer A requests an enqueue; hold until `prod_a_ack`.
- `prod_a_data`  in  WIDTH  producer A word; stable while `prod_a_req` is high.
- `prod_a_ack`  out  1  one-cycle pulse: word A accepted.
- `prod_b_req`, `prod_b_data`, `prod_b_ack`: same as producer A, for producer B.
- `cons_req`  in  1  consumer requests one word; hold until `cons_valid`.
- `cons_data`  out  WIDTH  dequeued word; valid while `cons_valid` is high, held afterwards.
- `cons_valid`  out  1  one-cycle pulse: `cons_data` valid.
- `q_data`  out  WIDTH  drives `fila.data_in`.
- `q_enqueue`  out  1  drives `fila.enqueue_in`.
- `q_dequeue`  out  1  drives `fila.dequeue_in`.
- `q_data_out`  in  WIDTH  from `fila.data_out`.
- `count`  out  4  occupancy, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.

## Operation
- States: IDLE, ENQ, ARM, COMMIT, CAPTURE, DONE. All outputs are registered.
- IDLE decision at each edge:
  - A dequeue is eligible when `cons_req && !empty`.
  - An enqueue is eligible when `(prod_a_req || prod_b_req) && !full`.
  - If only one is eligible, take it.
  - If both are eligible, the `turn` bit decides. `turn` = 0 favours dequeue. `turn` toggles after every served operation.
  - If neither is eligible, stay in IDLE.
- Enqueue, taken at the IDLE edge:
  - Grant goes to the requesting producer. If both request, grant goes to the one not granted last (`rr` pointer; after reset, A is favoured).
  - Set `q_enqueue` = 1, `q_data` = the granted word, the granted `ackX` = 1, `count` += 1, `rr` updated, state ENQ.
- ENQ: at the next edge, `q_enqueue` = 0 and `ack` = 0; go to IDLE. This gap cycle lets the producer drop or renew its request.
- Dequeue, taken at the IDLE edge: `q_dequeue` = 1, `count` -= 1, state ARM.
- ARM: `fila` arms its dequeue on this edge. Set `q_dequeue` = 0; go to COMMIT.
- COMMIT: `fila` shifts and updates `data_out` on this edge; go to CAPTURE.
- CAPTURE: `cons_data` = `q_data_out`, `cons_valid` = 1; go to DONE.
- DONE: `cons_valid` = 0; go to IDLE.
- `q_enqueue` is never high in ARM, COMMIT, CAPTURE or DONE. `q_dequeue` is high for exactly one cycle per dequeue.
- `cons_req` while empty is not an error. The request waits and is served after the next enqueue.
- `count` saturates only by construction: no enqueue when full, no dequeue when empty.
- `full` and `empty` are combinational from `count`.

## Timing
- Reset state:
  - `q_enqueue`, `q_dequeue`, `q_data`, `prod_a_ack`, `prod_b_ack`, `cons_valid`, `cons_data` = 0.
  - `count` = 0, `empty` = 1, `full` = 0.
  - State IDLE, `rr` → A, `turn` = 0.
- Enqueue:
  - Request sampled at edge E0; `ack` and `q_enqueue` are high during E0..E1; `fila` writes at E1.
  - Next IDLE decision is at E2, so maximum throughput is one word per 2 cycles.
- Dequeue:
  - Request sampled at E0; `q_dequeue` is high E0..E1; `fila` arms at E1 and shifts at E2.
  - Capture at E3; `cons_valid` is high E3..E4; next decision at E5.
- Reset asserted mid-operation: every output clears immediately. Any in-flight dequeue is abandoned with no `cons_valid`. `fila` clears in lockstep.

## Test plan
- Reset; A requests 0x11 → `q_enqueue` and `prod_a_ack` high for one cycle with `q_data` = 0x11; `count` = 1, `empty` = 0.
- A and B both hold requests (A: 0xA0.., B: 0xB0..) → grants alternate A, B, A, B; after 8 grants `full` = 1 and no further ack.
- Enqueue 0x01, 0x02, 0x03, then `cons_req` → single `q_dequeue` pulse; `cons_valid` 3 edges after the sample with `cons_data` = 0x01; `count` = 2.
- `cons_req` with `count` = 0 → no `q_dequeue` and no `cons_valid`; then A enqueues 0x55 → consumer receives 0x55.
- `count` = 4, `cons_req` and `prod_a_req` held continuously → operations alternate dequeue/enqueue; the checker flags any `q_enqueue` outside the ENQ cycle.
- `reset` pulsed during COMMIT → all outputs 0, `count` = 0, no `cons_valid` afterwards.
